fc_argmax: RTL and testbench
============================

# fc_argmax

Classification result stage directly downstream of the two-layer fully-connected block. Captures the final-layer output writes (`we`/`addr`/`data`) into an internal score buffer, starts a sequential signed-maximum scan when the FC chain signals `all_end`, and presents the winning class index with a valid/ack handshake to the host or top-level controller.

## Interface
- `NUM_CLASS`, 10: number of output neurons (buffer depth), 2..64.
- `BASE_ADDR`, 16'h0000: address of class 0 in the FC write stream.
- `IDX_W`, 6: width of `class_idx`; must satisfy 2^IDX_W ≥ NUM_CLASS.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `we`  in  1  write strobe from the FC output mux.
- `addr`  in  16  write address from the FC output mux.
- `data`  in  16  signed two's-complement neuron output.
- `all_end`  in  1  final-layer done level; a rising edge starts the scan.
- `result_ack`  in  1  consumer acknowledge; releases `result_valid`.
- `busy`  out  1  high in SCAN.
- `result_valid`  out  1  result held stable while high.
- `class_idx`  out  IDX_W  index of the maximum score.
- `class_score`  out  16  maximum score (see Configuration).
- `overrun`  out  1  sticky flag: a write was dropped during SCAN.

## Operation
- Buffer: NUM_CLASS × 16-bit registers. A write is accepted when `we`=1, BASE_ADDR ≤ `addr` < BASE_ADDR+NUM_CLASS, and state ≠ SCAN. It stores `data` at `addr`−BASE_ADDR. Out-of-range writes are silently ignored. Buffer contents are not cleared between images.
- Start detect: `all_end` is registered; start = `all_end` & ~`all_end_q`.
- FSM states:
  - IDLE: wait for start → SCAN. Load best=buf[0], best_idx=0, ptr=1.
  - SCAN: one entry per cycle. If buf[ptr] > best (signed, strict), update best and best_idx. Ties keep the lower index. When ptr=NUM_CLASS−1 and that entry has been compared → DONE. Latch `class_idx`/`class_score` and set `result_valid`=1.
  - DONE: hold outputs. On `result_ack`=1 → IDLE and clear `result_valid`. On start without ack → SCAN, clear `result_valid`, and rescan with the latest buffer contents.
- Start in SCAN is ignored. Start in DONE together with `result_ack` counts as a restart: the start takes priority.
- A write in the same cycle as start is stored before the scan reads that entry. The buffer write is committed at the clock edge on which the FSM enters SCAN.
- `overrun` is set by any in-range `we` during SCAN. It is cleared only by reset.
- Comparison uses signed 16-bit values. 16'h8000 is the most negative value. An all-equal buffer yields index 0.

## Timing
- Reset values: state=IDLE, `busy`=0, `result_valid`=0, `class_idx`=0, `class_score`=0, `overrun`=0, buffer=0, `all_end_q`=0.
- Start edge at cycle T (registered) → `busy`=1 from T+1.
- `result_valid`=1 and `busy`=0 at T+NUM_CLASS. This is NUM_CLASS−1 compare cycles plus the latch cycle.
- `result_ack` is sampled only while `result_valid`=1. `result_valid` falls the cycle after ack.
- Reset asserted mid-scan: everything returns to reset values immediately. No partial result is produced.

## Configuration
- `FC_ARGMAX_SCORE_EN` defined: `class_score` carries the winning 16-bit value, latched with `class_idx`.
- Not defined: `class_score` is tied to 16'h0000. The best-value register is still used internally, but no output latch is built.

## Test plan
- Reset: hold `reset_n`=0 while driving `we`/`all_end` → all outputs 0; buffer reads unchanged after release.
- Basic: write scores {5,−3,12,7,0,1,2,3,4,−1} to addr 0..9, pulse `all_end` → `result_valid`=1 exactly 10 cycles after the registered edge, `class_idx`=2, `class_score`=12 (macro on) / 0 (off); `result_ack` → `result_valid`=0 next cycle.
- Tie and sign: all entries 16'h8000 except idx 3 and idx 7 = 16'hFFFF → `class_idx`=3.
- Out-of-range and overrun: write addr 10 (value 16'h7FFF) → result is unaffected. Write addr 4 during SCAN → `overrun`=1 and the old value is used.
- Restart: leave the result unacknowledged, write idx 9 = 16'h7FFF, re-raise `all_end` → `result_valid` drops, then returns with `class_idx`=9.
- Mid-scan reset: assert `reset_n`=0 at scan cycle 4 → `busy`=0 and `result_valid`=0 immediately. After release, no result appears until a new `all_end` edge.

Source files
------------

// File: rtl/fc_argmax.sv
// Argmax stage behind the FC chain: buffers final-layer scores and scans them for the signed maximum.
// Optional FC_ARGMAX_SCORE_EN exposes the winning score on class_score; otherwise class_score is 0.
module fc_argmax #(
  parameter int          NUM_CLASS = 10,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [15:0]      addr,
  input  logic [15:0]      data,
  input  logic             all_end,
  input  logic             result_ack,
  output logic             busy,
  output logic             result_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [15:0]      class_score,
  output logic             overrun
);

  // state | meaning
  // IDLE  | waiting for an all_end rising edge
  // SCAN  | comparing one buffer entry per cycle
  // DONE  | result held until ack or restart
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam int               PTR_W = $clog2(NUM_CLASS);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_CLASS - 1);
  localparam logic [16:0]      DEPTH = 17'(NUM_CLASS);

  state_t                   state_q, state_d;
  logic signed [15:0]       buf_q [NUM_CLASS];
  logic signed [15:0]       buf_d [NUM_CLASS];
  logic signed [15:0]       best_q, best_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         best_idx_q, best_idx_d;
  logic                     all_end_q;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [IDX_W-1:0]         class_idx_q, class_idx_d;
  logic                     overrun_q, overrun_d;
`ifdef FC_ARGMAX_SCORE_EN
  logic [15:0]              score_q, score_d;
`endif

  logic [16:0]        addr_off;
  logic               in_range;
  logic               hit;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;
  logic               start;
  logic signed [15:0] cand;
  logic               take;

  assign addr_off = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = (addr >= BASE_ADDR) && (addr_off < DEPTH);
  assign wr_idx   = addr_off[PTR_W-1:0];
  assign hit      = we && in_range;
  assign wr_en    = hit && (state_q != S_SCAN);
  assign start    = all_end && !all_end_q;
  assign cand     = buf_q[ptr_q];
  assign take     = cand > best_q;

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    ptr_d       = ptr_q;
    best_idx_d  = best_idx_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    class_idx_d = class_idx_q;
    overrun_d   = overrun_q || (hit && (state_q == S_SCAN));
`ifdef FC_ARGMAX_SCORE_EN
    score_d     = score_q;
`endif
    for (int i = 0; i < NUM_CLASS; i++) begin
      buf_d[i] = (wr_en && (wr_idx == PTR_W'(i))) ? data : buf_q[i];
    end

    case (state_q)
      S_SCAN: begin
        if (take) begin
          best_d     = cand;
          best_idx_d = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          valid_d     = 1'b1;
          class_idx_d = IDX_W'(take ? ptr_q : best_idx_q);
`ifdef FC_ARGMAX_SCORE_EN
          score_d     = take ? cand : best_q;
`endif
        end
      end
      S_DONE: begin
        if (!start && result_ack) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Start wins over ack in DONE; best loads from buf_d so a same-cycle write to entry 0 is seen.
    if (start && (state_q != S_SCAN)) begin
      state_d    = S_SCAN;
      busy_d     = 1'b1;
      valid_d    = 1'b0;
      best_d     = buf_d[0];
      best_idx_d = '0;
      ptr_d      = PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      best_q      <= '0;
      ptr_q       <= '0;
      best_idx_q  <= '0;
      all_end_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      class_idx_q <= '0;
      overrun_q   <= 1'b0;
`ifdef FC_ARGMAX_SCORE_EN
      score_q     <= '0;
`endif
      for (int i = 0; i < NUM_CLASS; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      ptr_q       <= ptr_d;
      best_idx_q  <= best_idx_d;
      all_end_q   <= all_end;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      class_idx_q <= class_idx_d;
      overrun_q   <= overrun_d;
`ifdef FC_ARGMAX_SCORE_EN
      score_q     <= score_d;
`endif
      for (int i = 0; i < NUM_CLASS; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign class_idx    = class_idx_q;
  assign overrun      = overrun_q;
`ifdef FC_ARGMAX_SCORE_EN
  assign class_score  = score_q;
`else
  assign class_score  = 16'h0000;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: reset, basic argmax, ties/sign, out-of-range, overrun, restart, mid-scan reset.
module tb_fc_argmax;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [15:0] addr;
  logic [15:0] data;
  logic        all_end;
  logic        result_ack;
  logic        busy;
  logic        result_valid;
  logic [5:0]  class_idx;
  logic [15:0] class_score;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  fc_argmax dut (
    .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .data(data),
    .all_end(all_end), .result_ack(result_ack), .busy(busy),
    .result_valid(result_valid), .class_idx(class_idx),
    .class_score(class_score), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_score(input logic [15:0] v);
`ifdef FC_ARGMAX_SCORE_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; data = d;
    step();
    we = 1'b0;
  endtask

  // Raises all_end for one cycle and checks valid lands exactly 10 cycles after the registered edge.
  task automatic run_scan(input string tag);
    all_end = 1'b1;
    step();
    chk({tag, "_busy_t1"}, busy, 1);
    all_end = 1'b0;
    repeat (8) step();
    chk({tag, "_valid_t9"}, result_valid, 0);
    step();
    chk({tag, "_valid_t10"}, result_valid, 1);
    chk({tag, "_busy_t10"}, busy, 0);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("ack_valid_low", result_valid, 0);
  endtask

  initial begin
    logic [15:0] basic [10];
    basic = '{16'd5, 16'hFFFD, 16'd12, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF};

    reset_n = 1'b0; we = 1'b1; addr = 16'd0; data = 16'h1234;
    all_end = 1'b1; result_ack = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_score", class_score, 0);
    chk("rst_overrun", overrun, 0);
    we = 1'b0; all_end = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Buffer must still be all zero after reset with writes driven: index 0, score 0.
    run_scan("zero");
    chk("zero_idx", class_idx, 0);
    chk("zero_score", class_score, 0);
    ack();

    for (int i = 0; i < 10; i++) wr(16'(i), basic[i]);
    run_scan("basic");
    chk("basic_idx", class_idx, 2);
    chk("basic_score", class_score, exp_score(16'd12));
    chk("basic_hold_idx", class_idx, 2);
    ack();

    for (int i = 0; i < 10; i++) wr(16'(i), (i == 3 || i == 7) ? 16'hFFFF : 16'h8000);
    run_scan("tie");
    chk("tie_idx", class_idx, 3);
    chk("tie_score", class_score, exp_score(16'hFFFF));
    ack();

    wr(16'd10, 16'h7FFF);
    all_end = 1'b1;
    step();
    chk("ovr_busy", busy, 1);
    all_end = 1'b0;
    we = 1'b1; addr = 16'd4; data = 16'h7FFF;
    step();
    we = 1'b0;
    chk("ovr_flag", overrun, 1);
    repeat (7) step();
    chk("ovr_valid_t9", result_valid, 0);
    step();
    chk("ovr_valid_t10", result_valid, 1);
    chk("ovr_idx", class_idx, 3);
    chk("ovr_score", class_score, exp_score(16'hFFFF));

    // Restart from DONE without ack; the write in DONE is accepted.
    wr(16'd9, 16'h7FFF);
    chk("rs_valid_held", result_valid, 1);
    run_scan("rs");
    chk("rs_idx", class_idx, 9);
    chk("rs_score", class_score, exp_score(16'h7FFF));
    chk("rs_overrun_sticky", overrun, 1);

    // Start with ack and a write to entry 0 in the same cycle: start wins, write is seen.
    we = 1'b1; addr = 16'd0; data = 16'h7FFF; result_ack = 1'b1; all_end = 1'b1;
    step();
    we = 1'b0; result_ack = 1'b0; all_end = 1'b0;
    chk("sa_busy", busy, 1);
    chk("sa_valid", result_valid, 0);
    repeat (8) step();
    chk("sa_valid_t9", result_valid, 0);
    step();
    chk("sa_valid_t10", result_valid, 1);
    chk("sa_idx", class_idx, 0);
    chk("sa_score", class_score, exp_score(16'h7FFF));
    ack();

    all_end = 1'b1;
    step();
    all_end = 1'b0;
    repeat (3) step();
    chk("mr_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", result_valid, 0);
    chk("mr_overrun", overrun, 0);
    step();
    reset_n = 1'b1;
    repeat (15) step();
    chk("mr_no_result", result_valid, 0);
    chk("mr_idle_busy", busy, 0);
    run_scan("mr_new");
    chk("mr_new_idx", class_idx, 0);
    chk("mr_new_score", class_score, 0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
